// File: rtl/eeprom_host_port_ctrl.sv
// Host-side byte port arbiter for the save EEPROM array: streams save images in,
// dumps the whole array out, and tracks whether the game has modified it.
module eeprom_host_port_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    input  logic              dump_req,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [7:0]        dump_data,
    input  logic              dump_ready,
    output logic              dump_done,
    input  logic              eeprom_we,
    output logic              dirty,
    output logic              busy,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_address,
    output logic [7:0]        rom_wdata,
    input  logic [7:0]        rom_rdata
);

    typedef enum logic [2:0] {IDLE, D_ADDR, D_WAIT, D_SHOW, D_DONE} state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    state_t          state;
    logic            dump_pending;
    logic            wrote_during_dump;
    logic [ADDR_W:0] counter;
    logic [ADDR_W:0] counter_next;
    logic            in_dump;

    assign in_dump      = (state != IDLE);
    assign counter_next = counter + 1'b1;
    assign load_ready   = (state == IDLE) && !reset;
    assign busy         = (in_dump || dump_pending) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            dump_pending      <= 1'b0;
            wrote_during_dump <= 1'b0;
            counter           <= '0;
            rom_we            <= 1'b0;
            rom_address       <= '0;
            rom_wdata         <= '0;
            dump_valid        <= 1'b0;
            dump_done         <= 1'b0;
            dump_data         <= '0;
            dump_addr         <= '0;
            dirty             <= 1'b0;
        end else begin
            rom_we    <= 1'b0;
            dump_done <= 1'b0;
            if (eeprom_we)
                dirty <= 1'b1;
            if (eeprom_we && in_dump)
                wrote_during_dump <= 1'b1;
            // NOTE: later non-blocking assignments in this block override these
            // defaults, so the dump-start clear beats a same-cycle dump_req.
            if (dump_req && !in_dump)
                dump_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (load_valid) begin
                        rom_we      <= 1'b1;
                        rom_address <= load_addr;
                        rom_wdata   <= load_data;
                    end else if (dump_pending) begin
                        counter           <= '0;
                        dump_pending      <= 1'b0;
                        wrote_during_dump <= 1'b0;
                        rom_address       <= '0;
                        state             <= D_ADDR;
                    end
                end
                D_ADDR: begin
                    // Address is already on the port since entry, giving the
                    // array its read cycle before D_SHOW captures the byte.
                    rom_address <= counter[ADDR_W-1:0];
                    state       <= D_WAIT;
                end
                D_WAIT: begin
                    dump_data  <= rom_rdata;
                    dump_addr  <= counter[ADDR_W-1:0];
                    dump_valid <= 1'b1;
                    state      <= D_SHOW;
                end
                D_SHOW: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (counter == LAST_IDX) begin
                            state <= D_DONE;
                        end else begin
                            counter     <= counter_next;
                            rom_address <= counter_next[ADDR_W-1:0];
                            state       <= D_ADDR;
                        end
                    end
                end
                D_DONE: begin
                    dump_done <= 1'b1;
                    dirty     <= wrote_during_dump || eeprom_we;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_host_port_ctrl.sv
// Directed bench for eeprom_host_port_ctrl: loads, dumps with a byte-array
// model behind the ROM port, backpressure, arbitration, dirty and reset.
module tb_eeprom_host_port_ctrl;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 8192;

    logic              clk;
    logic              reset;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              load_ready;
    logic              dump_req;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [7:0]        dump_data;
    logic              dump_ready;
    logic              dump_done;
    logic              eeprom_we;
    logic              dirty;
    logic              busy;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        rom_wdata;
    logic [7:0]        rom_rdata;

    logic [7:0] mem     [DEPTH];
    logic [7:0] exp_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    eeprom_host_port_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_ready(dump_ready), .dump_done(dump_done),
        .eeprom_we(eeprom_we), .dirty(dirty), .busy(busy),
        .rom_we(rom_we), .rom_address(rom_address), .rom_wdata(rom_wdata),
        .rom_rdata(rom_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte array: data appears one clk after the address.
    always @(posedge clk) begin
        if (rom_we)
            mem[rom_address] <= rom_wdata;
        rom_rdata <= mem[rom_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consume one dump; negative indices disable the corresponding event.
    task automatic run_dump(input int first_exp, input int bp_idx, input int rst_idx,
                            input int we_idx, input int probe_idx, input int req_idx,
                            input logic exp_dirty);
        int idx = 0, neg = 0, prev_neg = 0, bp_cnt = 0, hold_cnt = 0, n_done = 0;
        int bad_addr = 0, bad_data = 0, bad_gap = 0, bad_hold = 0, bad_probe = 0;
        int post_bad = 0;
        bit in_bp = 0, probe_on = 0, prev_v = 0, finished = 0;
        logic [7:0]        hold_d = '0;
        logic [ADDR_W-1:0] hold_a = '0;
        logic [ADDR_W-1:0] idx_a;

        while (!finished && neg < 40000) begin
            @(negedge clk);
            neg++;
            dump_ready = 1'b1;
            eeprom_we  = 1'b0;
            dump_req   = 1'b0;
            if (dump_done) begin
                check("done_all_bytes", idx, DEPTH);
                check("done_latency", neg - prev_neg, 2);
                check("busy_at_done", busy, 0);
                check("dirty_at_done", dirty, exp_dirty);
                if (probe_on) begin
                    check("probe_ready_after_done", load_ready, 1);
                    @(negedge clk);
                    load_valid = 1'b0;
                    exp_mem[32'h0050] = 8'h5A;
                    check("probe_rom_we", rom_we, 1);
                    check("probe_rom_addr", rom_address, 13'h0050);
                    check("probe_rom_data", rom_wdata, 8'h5A);
                    check("load_keeps_clean", dirty, 0);
                end
                finished = 1;
            end else begin
                if (probe_on)
                    bad_probe += int'(load_ready);
                if (idx == DEPTH && neg == prev_neg + 1)
                    check("busy_before_done", busy, 1);
                if (dump_valid && !prev_v) begin
                    idx_a = idx[ADDR_W-1:0];
                    if (dump_addr !== idx_a) bad_addr++;
                    if (dump_data !== exp_mem[idx]) bad_data++;
                    if (idx == 0 && first_exp > 0)
                        check("first_latency", neg, first_exp);
                    else if (idx > 0 && idx - 1 != bp_idx && neg - prev_neg != 3)
                        bad_gap++;
                    if (idx == 0) begin
                        check("byte0_addr", dump_addr, 0);
                        check("byte0_data", dump_data, 8'h11);
                    end
                    if (idx == 1) check("byte1_data", dump_data, 8'h22);
                    if (idx == 16'h0010) check("burst0_data", dump_data, 8'hA0);
                    if (idx == DEPTH - 1) begin
                        check("last_addr", dump_addr, 13'h1FFF);
                        check("last_data", dump_data, 8'h33);
                    end
                    if (bp_idx >= 0 && idx == bp_idx + 1) begin
                        check("bp_next_addr", dump_addr, bp_idx + 1);
                        check("bp_release_gap", neg - prev_neg, 13);
                    end
                    if (idx == rst_idx) begin
                        reset      = 1'b1;
                        dump_ready = 1'b0;
                        @(negedge clk);
                        check("rst_dump_valid", dump_valid, 0);
                        check("rst_busy", busy, 0);
                        check("rst_dirty", dirty, 0);
                        check("rst_rom_we", rom_we, 0);
                        reset = 1'b0;
                        dump_ready = 1'b1;
                        repeat (20) begin
                            @(negedge clk);
                            n_done += int'(dump_done);
                        end
                        check("rst_no_done", n_done, 0);
                        finished = 1;
                    end else begin
                        prev_neg = neg;
                        hold_d   = dump_data;
                        hold_a   = dump_addr;
                        if (idx == we_idx) eeprom_we = 1'b1;
                        if (idx == req_idx) dump_req = 1'b1;
                        if (idx == probe_idx) begin
                            load_valid = 1'b1;
                            load_addr  = 13'h0050;
                            load_data  = 8'h5A;
                            probe_on   = 1;
                        end
                        if (idx == bp_idx) begin
                            in_bp      = 1;
                            bp_cnt     = 9;
                            dump_ready = 1'b0;
                        end
                        idx++;
                    end
                end else if (dump_valid) begin
                    if (!in_bp) begin
                        bad_hold++;
                    end else begin
                        hold_cnt++;
                        if (dump_data !== hold_d || dump_addr !== hold_a) bad_hold++;
                        if (bp_cnt > 0) begin
                            bp_cnt--;
                            dump_ready = 1'b0;
                        end else begin
                            in_bp = 0;
                        end
                    end
                end
            end
            prev_v = dump_valid;
        end

        if (!finished) check("dump_timeout", 1, 0);
        check("addr_order", bad_addr, 0);
        check("data_match", bad_data, 0);
        check("byte_gap", bad_gap, 0);
        check("hold_stable", bad_hold, 0);
        if (probe_idx >= 0) check("probe_stall", bad_probe, 0);
        if (bp_idx >= 0) check("bp_hold_cycles", hold_cnt, 10);
        if (rst_idx < 0) begin
            repeat (6) begin
                @(negedge clk);
                post_bad += int'(dump_done) + int'(busy);
            end
            check("post_dump_idle", post_bad, 0);
        end
    endtask

    logic [ADDR_W-1:0] ld_addr [3] = '{13'h0000, 13'h0001, 13'h1FFF};
    logic [7:0]        ld_data [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            exp_mem[i] = 8'(i * 7 + 3);
        end
        reset      = 1'b1;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        dump_req   = 1'b0;
        dump_ready = 1'b1;
        eeprom_we  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_load_ready", load_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_rom_we", rom_we, 0);
        check("reset_rom_addr", rom_address, 0);
        check("reset_rom_wdata", rom_wdata, 0);
        check("reset_dump_valid", dump_valid, 0);
        check("reset_dump_done", dump_done, 0);
        check("reset_dirty", dirty, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_load_ready", load_ready, 1);
        check("idle_busy", busy, 0);

        eeprom_we = 1'b1;
        @(negedge clk);
        eeprom_we = 1'b0;
        check("dirty_set", dirty, 1);

        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_addr  = ld_addr[i];
            load_data  = ld_data[i];
            exp_mem[ld_addr[i]] = ld_data[i];
            @(negedge clk);
            check("load_rom_we", rom_we, 1);
            check("load_rom_addr", rom_address, ld_addr[i]);
            check("load_rom_data", rom_wdata, ld_data[i]);
        end
        load_valid = 1'b0;
        @(negedge clk);
        check("load_rom_we_off", rom_we, 0);

        // Four-byte burst with a dump request in its first cycle.
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_addr  = 13'(16'h0010 + i);
            load_data  = 8'(8'hA0 + i);
            exp_mem[16'h0010 + i] = 8'(8'hA0 + i);
            dump_req   = (i == 0);
            @(negedge clk);
            dump_req = 1'b0;
            check("burst_rom_we", rom_we, 1);
            check("burst_rom_addr", rom_address, 16'h0010 + i);
            if (i == 0) check("pending_busy", busy, 1);
        end
        load_valid = 1'b0;
        run_dump(3, -1, -1, -1, 16'h1000, 16'h0200, 1'b0);

        eeprom_we = 1'b1;
        @(negedge clk);
        eeprom_we = 1'b0;
        check("dirty_set_again", dirty, 1);
        dump_req = 1'b1;
        run_dump(4, 16'h0100, 16'h0400, -1, -1, -1, 1'b0);

        dump_req = 1'b1;
        run_dump(4, -1, -1, 16'h0800, -1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eeprom_host_port_ctrl.md
Name: eeprom_host_port_ctrl

Overview:
- Owns the host-side byte port of the 8 KiB save EEPROM array: rom_we, rom_address_in, rom_data_in and rom_data_out.
- Shares that port between two requesters:
  - a save-load stream (bridge writes a save image into the array);
  - a save-dump sequencer (reads the whole array out to the bridge).
- Tracks a dirty flag from the EEPROM's serial-side write strobe, so the system knows when the save must be written back.

Parameters:
- ADDR_W, 13, address width of the EEPROM array.
- DEPTH, 8192, number of bytes dumped per dump request; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  load byte offered.
- load_addr  in  ADDR_W  load byte address.
- load_data  in  8  load byte value.
- load_ready  out  1  load byte accepted this cycle when load_valid and load_ready are both high.
- dump_req  in  1  single-cycle pulse requesting a full dump.
- dump_valid  out  1  dump byte presented.
- dump_addr  out  ADDR_W  address of the presented dump byte.
- dump_data  out  8  value of the presented dump byte.
- dump_ready  in  1  consumer takes the dump byte this cycle.
- dump_done  out  1  one-cycle pulse after the last dump byte transfers.
- eeprom_we  in  1  EEPROM serial-side write strobe (level; may stay high for several clk).
- dirty  out  1  array modified by the game since the last completed dump.
- busy  out  1  high when state is not IDLE or a dump is pending.
- rom_we  out  1  drives rom_we of the EEPROM array.
- rom_address  out  ADDR_W  drives rom_address_in.
- rom_wdata  out  8  drives rom_data_in.
- rom_rdata  in  8  from rom_data_out; valid one clk after rom_address is presented.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Reset values:
  - state = IDLE, dump_pending 0, dump counter 0;
  - rom_we 0, rom_address 0, rom_wdata 0;
  - load_ready 0 (combinational from state);
  - dump_valid 0, dump_done 0, dump_data 0, dump_addr 0;
  - dirty 0, busy 0.
- Reset mid-dump or mid-load abandons the operation immediately: no rom_we in the following cycle, pending request dropped, dirty cleared.
- All outputs except load_ready and busy are registered.
- Dump request latching:
  - dump_req in any state other than the DUMP states sets dump_pending.
  - dump_req during a dump is ignored; it is not queued.
- State IDLE:
  - load_ready = 1.
  - Load accept (load_valid=1): next cycle rom_we=1 for exactly one cycle, with rom_address=load_addr and rom_wdata=load_data. Back-to-back loads run at 1 byte/clk.
  - Loads have priority: a dump starts only in an IDLE cycle where dump_pending=1 and load_valid=0. Then counter <= 0, dump_pending <= 0, go to D_ADDR.
- State D_ADDR:
  - rom_address <= counter, rom_we 0.
  - Next state D_WAIT.
- State D_WAIT:
  - Waits one cycle for array read latency.
  - Next state D_SHOW.
- State D_SHOW:
  - On entry, capture dump_data <= rom_rdata and dump_addr <= counter; dump_valid = 1.
  - Hold dump_valid, dump_data and dump_addr stable until dump_ready=1.
  - On the handshake cycle, dump_valid drops the next cycle.
  - If counter == DEPTH-1: go to D_DONE.
  - Otherwise counter <= counter+1 and go to D_ADDR.
  - Minimum 3 clk per byte.
- State D_DONE:
  - dump_done = 1 for one cycle.
  - dirty <= wrote_during_dump (see below).
  - Return to IDLE.
- load_ready = 0 in every non-IDLE state. Load bytes stall; none are dropped.
- Dirty tracking:
  - eeprom_we = 1 in any cycle sets dirty.
  - wrote_during_dump is cleared at dump start and set by eeprom_we during D_ADDR, D_WAIT, D_SHOW or D_DONE.
  - Set wins over the D_DONE clear.
  - Host load writes never set dirty.
- Counter: ADDR_W+1 bits wide; the terminal compare is against DEPTH-1, with no wrap past it.
- Snapshot consistency is not guaranteed: the game can still write the array via the serial side during a dump. dirty reflects this.

Test Plan:
- Load: reset, then three back-to-back loads (0x0000=0x11, 0x0001=0x22, 0x1FFF=0x33) -> rom_we high on the 3 consecutive following cycles with matching address/data. Dump then returns 0x11, 0x22 at addrs 0/1 and 0x33 at addr 0x1FFF.
- Dump timing with an always-ready consumer:
  - dump_req -> first dump_valid 3 clk after dump start, bytes every 3 clk, 8192 bytes in address order;
  - dump_done pulses once, 1 clk after the last handshake, with busy falling in the same cycle.
- Backpressure: hold dump_ready=0 for 10 clk on byte 0x0100 -> dump_valid/dump_data/dump_addr stable all 10 clk, no address advance. Release -> 0x0101 follows.
- Arbitration:
  - dump_req in the same cycle as a 4-byte load_valid burst -> all 4 loads complete first, then the dump starts.
  - load_valid during the dump -> load_ready 0 until dump_done, then accepted.
- Dirty: eeprom_we pulse -> dirty=1. A dump with no further writes -> dirty=0 at dump_done. A dump with eeprom_we asserted at byte 0x0800 -> dirty remains 1 after dump_done.
- Reset at byte 0x0400 of a dump -> next cycle dump_valid=0, busy=0, dirty=0, no dump_done. A fresh dump_req restarts at address 0.
